// File: rtl/spart_pkg.sv
// Shared types and constants for the SPART receive path.
package spart_pkg;

   localparam int unsigned OSR       = 16;  // brg_tick pulses per bit period
   localparam int unsigned SAMPLE_PT = 7;   // os_cnt value that qualifies the start bit
   localparam int unsigned DATA_BITS = 8;   // data bits per frame, LSB first

   localparam logic [1:0] ADDR_DATA   = 2'd0;
   localparam logic [1:0] ADDR_STATUS = 2'd1;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_IDLE
   } rx_state_t;

endpackage

// File: rtl/spart_receive_if.sv
// Serial-line, baud-tick and register-read signals of the SPART receiver.
interface spart_receive_if;

   logic       brg_tick;
   logic       rxd;
   logic       iocs;
   logic       iorw;
   logic [1:0] ioaddr;
   logic [7:0] rx_data;
   logic       rda;
   logic       ferr;
   logic       oerr;
   logic       rx_busy;

   // Bus/line side: drives the receiver and observes its flags.
   modport master (
      output brg_tick, rxd, iocs, iorw, ioaddr,
      input  rx_data, rda, ferr, oerr, rx_busy
   );

   // Receiver side.
   modport slave (
      input  brg_tick, rxd, iocs, iorw, ioaddr,
      output rx_data, rda, ferr, oerr, rx_busy
   );

endinterface

// File: rtl/spart_rx_sync.sv
// N-stage synchroniser for an asynchronous input; presets to 1 (idle line level).
module spart_rx_sync #(
   parameter int unsigned Stages = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic [Stages-1:0] sync_q, sync_d;

   // Shift the raw input one stage per clock.
   always_comb begin
      sync_d = {sync_q[Stages-2:0], d_i};
   end

   // Synchroniser flops, preset high so reset never looks like a start bit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q <= '1;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/spart_receive.sv
// SPART receive stage: 16x-oversampled 8N1 deserialiser with a one-byte holding
// register, data-available flag and sticky framing/overrun flags.
module spart_receive
   import spart_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   spart_receive_if.slave bus
);

   localparam logic [3:0] OsLast   = 4'(OSR - 1);
   localparam logic [3:0] SamplePt = 4'(SAMPLE_PT);
   localparam logic [3:0] LastBit  = 4'(DATA_BITS - 1);

   logic       rxd_s;
   rx_state_t  state_q, state_d;
   logic [3:0] os_cnt_q, os_cnt_d;
   logic [3:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] shift_q, shift_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       rda_q, rda_d;
   logic       ferr_q, ferr_d;
   logic       oerr_q, oerr_d;
   logic       frame_done;
   logic       data_rd;
   logic       status_rd;

   spart_rx_sync #(
      .Stages (2)
   ) u_rxd_sync (
      .clk (clk),
      .rst (rst),
      .d_i (bus.rxd),
      .q_o (rxd_s)
   );

   assign data_rd   = bus.iocs & bus.iorw & (bus.ioaddr == ADDR_DATA);
   assign status_rd = bus.iocs & bus.iorw & (bus.ioaddr == ADDR_STATUS);

   // Frame FSM: next state, oversample/bit counters and shift register.
   always_comb begin
      state_d    = state_q;
      os_cnt_d   = os_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      frame_done = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.brg_tick && !rxd_s) begin
               state_d  = START;
               os_cnt_d = '0;
            end
         end
         START: begin
            if (bus.brg_tick) begin
               if (os_cnt_q == SamplePt) begin
                  os_cnt_d  = '0;
                  bit_cnt_d = '0;
                  // A line already back high at mid-bit was a glitch.
                  state_d   = rxd_s ? IDLE : DATA;
               end else begin
                  os_cnt_d = os_cnt_q + 4'd1;
               end
            end
         end
         DATA: begin
            if (bus.brg_tick) begin
               if (os_cnt_q == OsLast) begin
                  os_cnt_d  = '0;
                  shift_d   = {rxd_s, shift_q[7:1]};
                  bit_cnt_d = bit_cnt_q + 4'd1;
                  if (bit_cnt_q == LastBit) begin
                     state_d = STOP;
                  end
               end else begin
                  os_cnt_d = os_cnt_q + 4'd1;
               end
            end
         end
         STOP: begin
            if (bus.brg_tick) begin
               if (os_cnt_q == OsLast) begin
                  os_cnt_d   = '0;
                  frame_done = 1'b1;
                  state_d    = rxd_s ? IDLE : WAIT_IDLE;
               end else begin
                  os_cnt_d = os_cnt_q + 4'd1;
               end
            end
         end
         WAIT_IDLE: begin
            // Hold off until a held-low line (break) is released.
            if (rxd_s) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Holding register and flags; a completing frame overrides a same-cycle read.
   always_comb begin
      rx_data_d = rx_data_q;
      rda_d     = rda_q;
      ferr_d    = ferr_q;
      oerr_d    = oerr_q;
      if (data_rd) begin
         rda_d = 1'b0;
      end
      if (status_rd) begin
         ferr_d = 1'b0;
         oerr_d = 1'b0;
      end
      if (frame_done) begin
         rx_data_d = shift_q;
         rda_d     = 1'b1;
         if (rda_q && !data_rd) begin
            oerr_d = 1'b1;
         end
         if (!rxd_s) begin
            ferr_d = 1'b1;
         end
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         os_cnt_q  <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         rx_data_q <= '0;
         rda_q     <= 1'b0;
         ferr_q    <= 1'b0;
         oerr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         os_cnt_q  <= os_cnt_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         rx_data_q <= rx_data_d;
         rda_q     <= rda_d;
         ferr_q    <= ferr_d;
         oerr_q    <= oerr_d;
      end
   end

   assign bus.rx_data = rx_data_q;
   assign bus.rda     = rda_q;
   assign bus.ferr    = ferr_q;
   assign bus.oerr    = oerr_q;
   assign bus.rx_busy = (state_q != IDLE);

endmodule

// File: tb/tb_spart_receive.sv
// Directed bench for spart_receive: frame table plus glitch, break, overrun and
// mid-frame reset sequences. One bit period is 16 ticks x 4 clk = 64 clk.
module tb_spart_receive;
   import spart_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;
   int   tcnt  = 0;

   always #5 clk = ~clk;

   spart_receive_if bus ();

   spart_receive dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [7:0] data;
      logic       pre_drd;
      logic       pre_srd;
      logic       rd_done;
      logic [7:0] exp_data;
      logic       exp_rda;
      logic       exp_ferr;
      logic       exp_oerr;
   } vec_t;

   vec_t vecs [6];

   // brg_tick: one clk high every 4 clk; tcnt==0 means the next posedge is a tick.
   initial begin
      bus.brg_tick = 1'b0;
      forever begin
         @(negedge clk);
         tcnt = (tcnt + 1) % 4;
         bus.brg_tick = (tcnt == 0);
      end
   end

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %02h expected %02h", name, act, exp);
      end
   endtask

   task automatic check_b(input string name, input logic act, input logic exp);
      check(name, {7'd0, act}, {7'd0, exp});
   endtask

   task automatic bus_access(input logic rw, input logic [1:0] addr);
      @(negedge clk);
      bus.iocs   = 1'b1;
      bus.iorw   = rw;
      bus.ioaddr = addr;
      @(negedge clk);
      bus.iocs   = 1'b0;
      bus.iorw   = 1'b0;
      bus.ioaddr = 2'd0;
   endtask

   task automatic sync_tick();
      do begin
         @(negedge clk);
         #1;
      end while (tcnt != 0);
   endtask

   // Start bit is driven just before posedge T0; the stop bit is sampled at T0+612,
   // so a read raised at loop step 612 lands exactly on the frame-complete cycle.
   task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                             input logic rd_done, input logic [1:0] rd_addr);
      logic [9:0] frame;
      logic [3:0] b;
      frame = {stop_bit, data, 1'b0};
      sync_tick();
      bus.rxd = frame[0];
      for (int c = 1; c <= 640; c++) begin
         @(negedge clk);
         if (c < 640) begin
            b = 4'(c / 64);
            bus.rxd = frame[b];
         end
         if (rd_done && c == 612) begin
            bus.iocs   = 1'b1;
            bus.iorw   = 1'b1;
            bus.ioaddr = rd_addr;
         end else if (rd_done && c == 613) begin
            bus.iocs   = 1'b0;
            bus.iorw   = 1'b0;
            bus.ioaddr = 2'd0;
         end
      end
   endtask

   initial begin
      bus.rxd    = 1'b1;
      bus.iocs   = 1'b0;
      bus.iorw   = 1'b0;
      bus.ioaddr = 2'd0;
      rst        = 1'b0;
      repeat (3) @(negedge clk);
      check  ("reset rx_data", bus.rx_data, 8'h00);
      check_b("reset rda", bus.rda, 1'b0);
      check_b("reset ferr", bus.ferr, 1'b0);
      check_b("reset oerr", bus.oerr, 1'b0);
      check_b("reset rx_busy", bus.rx_busy, 1'b0);
      rst = 1'b1;
      repeat (10) @(negedge clk);

      //             data   pdrd  psrd  rddone exp    rda   ferr  oerr
      vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0};
      vecs[1] = '{8'h3C, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{8'h11, 1'b1, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0};
      vecs[3] = '{8'h22, 1'b0, 1'b0, 1'b0, 8'h22, 1'b1, 1'b0, 1'b1};
      vecs[4] = '{8'h11, 1'b1, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0};
      vecs[5] = '{8'h22, 1'b0, 1'b0, 1'b1, 8'h22, 1'b1, 1'b0, 1'b0};

      for (int i = 0; i < 6; i++) begin
         if (vecs[i].pre_drd) bus_access(1'b1, ADDR_DATA);
         if (vecs[i].pre_srd) bus_access(1'b1, ADDR_STATUS);
         send_frame(vecs[i].data, 1'b1, vecs[i].rd_done, ADDR_DATA);
         check  ($sformatf("v%0d rx_data", i), bus.rx_data, vecs[i].exp_data);
         check_b($sformatf("v%0d rda", i), bus.rda, vecs[i].exp_rda);
         check_b($sformatf("v%0d ferr", i), bus.ferr, vecs[i].exp_ferr);
         check_b($sformatf("v%0d oerr", i), bus.oerr, vecs[i].exp_oerr);
         check_b($sformatf("v%0d rx_busy", i), bus.rx_busy, 1'b0);
      end

      // Writes and unmapped reads leave rda alone; a data read clears it.
      bus_access(1'b0, ADDR_DATA);
      check_b("write keeps rda", bus.rda, 1'b1);
      bus_access(1'b1, 2'd2);
      check_b("addr2 read keeps rda", bus.rda, 1'b1);
      bus_access(1'b1, ADDR_DATA);
      check_b("data read clears rda", bus.rda, 1'b0);

      // Start-bit glitch: 5 ticks low, then high.
      sync_tick();
      bus.rxd = 1'b0;
      repeat (10) @(negedge clk);
      check_b("glitch busy", bus.rx_busy, 1'b1);
      repeat (10) @(negedge clk);
      bus.rxd = 1'b1;
      repeat (30) @(negedge clk);
      check_b("glitch idle", bus.rx_busy, 1'b0);
      check_b("glitch rda", bus.rda, 1'b0);
      send_frame(8'h3C, 1'b1, 1'b0, ADDR_DATA);
      check  ("post-glitch rx_data", bus.rx_data, 8'h3C);
      check_b("post-glitch rda", bus.rda, 1'b1);

      // Framing error with the line held low; status read on the completing cycle.
      bus_access(1'b1, ADDR_DATA);
      send_frame(8'h81, 1'b0, 1'b1, ADDR_STATUS);
      check  ("break rx_data", bus.rx_data, 8'h81);
      check_b("break rda", bus.rda, 1'b1);
      check_b("break ferr", bus.ferr, 1'b1);
      check_b("break oerr", bus.oerr, 1'b0);
      check_b("break busy", bus.rx_busy, 1'b1);
      repeat (96) @(negedge clk);
      check_b("break hold busy", bus.rx_busy, 1'b1);
      bus.rxd = 1'b1;
      repeat (6) @(negedge clk);
      check_b("break release idle", bus.rx_busy, 1'b0);
      bus_access(1'b1, ADDR_STATUS);
      check_b("status read clears ferr", bus.ferr, 1'b0);
      check_b("status read keeps rda", bus.rda, 1'b1);

      // Asynchronous reset in the middle of the data bits of 0xFF.
      sync_tick();
      bus.rxd = 1'b0;
      repeat (64) @(negedge clk);
      bus.rxd = 1'b1;
      repeat (150) @(negedge clk);
      check_b("mid-frame busy", bus.rx_busy, 1'b1);
      #3 rst = 1'b0;
      #1;
      check  ("async rst rx_data", bus.rx_data, 8'h00);
      check_b("async rst rda", bus.rda, 1'b0);
      check_b("async rst ferr", bus.ferr, 1'b0);
      check_b("async rst oerr", bus.oerr, 1'b0);
      check_b("async rst busy", bus.rx_busy, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      repeat (20) @(negedge clk);
      check_b("after rst idle", bus.rx_busy, 1'b0);
      send_frame(8'h5A, 1'b1, 1'b0, ADDR_DATA);
      check  ("post-rst rx_data", bus.rx_data, 8'h5A);
      check_b("post-rst rda", bus.rda, 1'b1);
      check_b("post-rst ferr", bus.ferr, 1'b0);
      check_b("post-rst oerr", bus.oerr, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
